// File: rtl/seq_digit_mult_pkg.sv
// mult_pkg: shared FSM state type, sizing helpers and conditional negate for seq_digit_mult.
package mult_pkg;

    typedef enum logic [1:0] {IDLE, MUL, FIX, DONE} state_t;

    // Widest value cond_negate handles; callers zero-extend in and truncate out.
    localparam int MAX_W = 128;

    function automatic int num_digits(input int width, input int digit);
        return width / digit;
    endfunction

    function automatic int cnt_width(input int n);
        return (n * n > 1) ? $clog2(n * n) : 1;
    endfunction

    // Truncating the result keeps the low bits of a true two's-complement negate.
    function automatic logic [MAX_W-1:0] cond_negate(input logic [MAX_W-1:0] value, input logic en);
        return en ? (~value + MAX_W'(1)) : value;
    endfunction

endpackage

// File: rtl/seq_digit_mult_digit.sv
// digit_mult: combinational unsigned DIGIT x DIGIT -> 2*DIGIT multiplier.
module digit_mult #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0]   a,
    input  logic [DIGIT-1:0]   b,
    output logic [2*DIGIT-1:0] p
);

    assign p = (2*DIGIT)'(a) * (2*DIGIT)'(b);

endmodule

// File: rtl/seq_digit_mult.sv
// seq_digit_mult: iterative sign-magnitude multiplier, one DIGIT x DIGIT partial product per cycle.
module seq_digit_mult
    import mult_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               signed_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] p
);

    localparam int N  = num_digits(WIDTH, DIGIT);
    localparam int CW = cnt_width(N);
    localparam int PW = 2 * WIDTH;

    if (WIDTH % DIGIT != 0) begin : g_bad_digit
        $error("seq_digit_mult: WIDTH must be a multiple of DIGIT");
    end

    state_t            state;
    logic [WIDTH-1:0]  mag_a;
    logic [WIDTH-1:0]  mag_b;
    logic              neg;
    logic [PW-1:0]     acc;
    logic [CW-1:0]     k;
    logic [CW-1:0]     di;
    logic [CW-1:0]     dj;
    logic [DIGIT-1:0]  da;
    logic [DIGIT-1:0]  db;
    logic [2*DIGIT-1:0] pp;
    logic [PW-1:0]     pp_sh;

    // k walks b digits fastest: k = i*N + j.
    always_comb begin
        di    = CW'(int'(k) / N);
        dj    = CW'(int'(k) % N);
        da    = mag_a[DIGIT*int'(di) +: DIGIT];
        db    = mag_b[DIGIT*int'(dj) +: DIGIT];
        pp_sh = PW'(pp) << (DIGIT * (int'(di) + int'(dj)));
    end

    digit_mult #(.DIGIT(DIGIT)) u_digit_mult (
        .a (da),
        .b (db),
        .p (pp)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            p         <= '0;
            acc       <= '0;
            k         <= '0;
            mag_a     <= '0;
            mag_b     <= '0;
            neg       <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    mag_a    <= WIDTH'(cond_negate(MAX_W'(a), signed_mode & a[WIDTH-1]));
                    mag_b    <= WIDTH'(cond_negate(MAX_W'(b), signed_mode & b[WIDTH-1]));
                    neg      <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                    acc      <= '0;
                    k        <= '0;
                    in_ready <= 1'b0;
                    state    <= MUL;
                end
                MUL: begin
                    acc <= acc + pp_sh;
                    k   <= k + CW'(1);
                    if (k == CW'(N * N - 1))
                        state <= FIX;
                end
                FIX: begin
                    p         <= PW'(cond_negate(MAX_W'(acc), neg));
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
